lcd_fill_seq: RTL

LCD_FILL_SEQ -- requirements
Module: lcd_fill_seq

---
 rtl/lcd_fill_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_fill_seq.sv
// LCD initialise-and-fill sequencer: drives an 8-bit SPI byte transmitter through
// the sleep-out/display-on/pixel-format init, then paints the whole panel one colour.
module lcd_fill_seq #(
  parameter int          COLS        = 240,
  parameter int          ROWS        = 240,
  parameter logic [23:0] SLPOUT_WAIT = 24'd6_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fill_req,
  input  logic [15:0] fill_color,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        cs,
  output logic        dc,
  output logic        init_done,
  output logic        busy,
  output logic        done
);

  localparam int NPIX = COLS * ROWS;
  localparam int PW   = $clog2(NPIX + 1);

  localparam logic [15:0]   COL_LAST  = 16'(COLS - 1);
  localparam logic [15:0]   ROW_LAST  = 16'(ROWS - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(NPIX - 1);
  localparam logic [23:0]   WAIT_LAST = SLPOUT_WAIT - 24'd1;

  localparam logic [2:0] S_INIT_CMD  = 3'd0;
  localparam logic [2:0] S_INIT_WAIT = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_CASET     = 3'd3;
  localparam logic [2:0] S_RASET     = 3'd4;
  localparam logic [2:0] S_RAMWR     = 3'd5;
  localparam logic [2:0] S_PIXEL     = 3'd6;
  localparam logic [2:0] S_FINISH    = 3'd7;

  logic [2:0]    state, state_n;
  logic [2:0]    idx, idx_n;          // bytes already issued within the current command
  logic [23:0]   wait_cnt, wait_n;
  logic [PW-1:0] pix_cnt, pix_n;      // index of the pixel being sent
  logic          lo, lo_n;            // low colour byte of the current pixel is in flight
  logic          outstanding, out_n;
  logic [15:0]   color, color_n;
  logic          cs_n, dc_n, start_n, busy_n, done_n, init_n;
  logic [7:0]    data_n;

  logic          ack;
  logic          send;
  logic [7:0]    send_byte;
  logic          send_dc;

  // Window address bytes after the command: 0x00, 0x00, last[15:8], last[7:0].
  function automatic logic [7:0] addr_byte(input logic [2:0] i, input logic [15:0] last);
    case (i)
      3'd3:    return last[15:8];
      3'd4:    return last[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // A tx_done with nothing in flight is noise from the transmitter and is dropped.
  assign ack = tx_done && outstanding;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    wait_n    = wait_cnt;
    pix_n     = pix_cnt;
    lo_n      = lo;
    out_n     = outstanding;
    color_n   = color;
    cs_n      = cs;
    dc_n      = dc;
    data_n    = tx_data;
    busy_n    = busy;
    init_n    = init_done;
    start_n   = 1'b0;
    done_n    = 1'b0;
    send      = 1'b0;
    send_byte = 8'h00;
    send_dc   = 1'b0;

    if (ack) out_n = 1'b0;

    case (state)
      S_INIT_CMD: begin
        if (cs) begin
          cs_n = 1'b0;
        end else if (idx == 3'd0 && !outstanding) begin
          send = 1'b1; send_byte = 8'h11; idx_n = 3'd1;
        end else if (ack) begin
          case (idx)
            3'd1: begin
              if (SLPOUT_WAIT == 24'd0) begin
                send = 1'b1; send_byte = 8'h29; idx_n = 3'd2;
              end else begin
                state_n = S_INIT_WAIT; wait_n = 24'd0;
              end
            end
            3'd2: begin send = 1'b1; send_byte = 8'h3A; idx_n = 3'd3; end
            3'd3: begin send = 1'b1; send_byte = 8'h55; send_dc = 1'b1; idx_n = 3'd4; end
            default: begin
              cs_n = 1'b1; init_n = 1'b1; state_n = S_IDLE; idx_n = 3'd0;
            end
          endcase
        end
      end

      S_INIT_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          send = 1'b1; send_byte = 8'h29; idx_n = 3'd2;
          state_n = S_INIT_CMD; wait_n = 24'd0;
        end else begin
          wait_n = wait_cnt + 24'd1;
        end
      end

      S_IDLE: begin
        // done is high only on the completion cycle, where a new request is refused.
        if (fill_req && !done) begin
          color_n = fill_color; busy_n = 1'b1; cs_n = 1'b0;
          state_n = S_CASET; idx_n = 3'd0;
        end
      end

      S_CASET: begin
        if (idx == 3'd0 && !outstanding) begin
          send = 1'b1; send_byte = 8'h2A; idx_n = 3'd1;
        end else if (ack) begin
          if (idx == 3'd5) begin
            send = 1'b1; send_byte = 8'h2B; state_n = S_RASET; idx_n = 3'd1;
          end else begin
            send = 1'b1; send_byte = addr_byte(idx, COL_LAST); send_dc = 1'b1;
            idx_n = idx + 3'd1;
          end
        end
      end

      S_RASET: begin
        if (ack) begin
          if (idx == 3'd5) begin
            send = 1'b1; send_byte = 8'h2C; state_n = S_RAMWR; idx_n = 3'd0;
          end else begin
            send = 1'b1; send_byte = addr_byte(idx, ROW_LAST); send_dc = 1'b1;
            idx_n = idx + 3'd1;
          end
        end
      end

      S_RAMWR: begin
        if (ack) begin
          send = 1'b1; send_byte = color[15:8]; send_dc = 1'b1;
          state_n = S_PIXEL; pix_n = '0; lo_n = 1'b0;
        end
      end

      S_PIXEL: begin
        if (ack) begin
          send = 1'b1; send_dc = 1'b1;
          if (!lo) begin
            send_byte = color[7:0]; lo_n = 1'b1;
            if (pix_cnt == PIX_LAST) state_n = S_FINISH;
          end else begin
            send_byte = color[15:8]; lo_n = 1'b0; pix_n = pix_cnt + PW'(1);
          end
        end
      end

      S_FINISH: begin
        if (ack) begin
          cs_n = 1'b1; busy_n = 1'b0; done_n = 1'b1; state_n = S_IDLE;
          pix_n = '0; lo_n = 1'b0;
        end
      end

      default: state_n = S_INIT_CMD;
    endcase

    if (send) begin
      start_n = 1'b1;
      data_n  = send_byte;
      dc_n    = send_dc;
      out_n   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT_CMD;
      idx         <= 3'd0;
      wait_cnt    <= 24'd0;
      pix_cnt     <= '0;
      lo          <= 1'b0;
      outstanding <= 1'b0;
      color       <= 16'h0000;
      cs          <= 1'b1;
      dc          <= 1'b0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      wait_cnt    <= wait_n;
      pix_cnt     <= pix_n;
      lo          <= lo_n;
      outstanding <= out_n;
      color       <= color_n;
      cs          <= cs_n;
      dc          <= dc_n;
      tx_data     <= data_n;
      tx_start    <= start_n;
      busy        <= busy_n;
      done        <= done_n;
      init_done   <= init_n;
    end
  end

endmodule
